sb_drain_ctrl: RTL and testbench

- Sequences committed stores out of the store buffer head into the D-cache store port, one at a time.
- Arbitrates that single D-cache port between the drain and LSU load requests.
- Serialises non-idempotent (MMIO) stores by waiting for the write response.
- Services fence drain requests. Sits between the ROB commit stage, the store buffer and the D-cache.

---
 rtl/sb_drain_ctrl.sv | 129 ++++++++++++
 tb/tb_sb_drain_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_drain_ctrl.sv
// rtl/sb_drain_ctrl.sv - store buffer drain sequencer and D-cache port arbiter
module sb_drain_ctrl #(
    parameter int SB_DEPTH       = 8,
    parameter int COMMIT_WIDTH   = 2,
    parameter int HIGH_WATER     = 6,
    parameter int MAX_LOAD_STALL = 4,
    localparam int CNT_W = $clog2(SB_DEPTH + 1),
    localparam int CMT_W = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CMT_W-1:0] commit_store_cnt,
    input  logic             sb_head_valid,
    input  logic [31:0]      sb_head_addr,
    input  logic [31:0]      sb_head_data,
    input  logic [3:0]       sb_head_mask,
    input  logic             sb_head_non_idem,
    output logic             sb_pop,
    input  logic             load_req_valid,
    output logic             load_req_grant,
    output logic             dc_st_req,
    output logic [31:0]      dc_st_addr,
    output logic [31:0]      dc_st_data,
    output logic [3:0]       dc_st_mask,
    output logic             dc_st_uncached,
    input  logic             dc_st_ack,
    input  logic             dc_st_done,
    input  logic             fence_req,
    output logic             fence_done,
    output logic [CNT_W-1:0] committed_cnt,
    output logic             mmio_busy
);

    localparam int ST_W = $clog2(MAX_LOAD_STALL + 1);
    localparam logic [CNT_W-1:0] HW_LVL    = CNT_W'(HIGH_WATER);
    localparam logic [ST_W-1:0]  STALL_MAX = ST_W'(MAX_LOAD_STALL);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, MMIO_WAIT = 2'd2} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_cnt_sum;
    logic [ST_W-1:0]  r_starve;
    logic             r_fence_pending;
    logic             w_store_eligible;
    logic             w_urgent;
    logic             w_issue;

    assign w_store_eligible = (r_cnt != '0) && sb_head_valid;
    assign w_urgent = r_fence_pending || (r_cnt >= HW_LVL) || (r_starve == STALL_MAX);
    assign w_cnt_sum = {1'b0, r_cnt} + (CNT_W+1)'(commit_store_cnt) - (CNT_W+1)'(sb_pop);
    assign committed_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_issue) w_state_nxt = REQ;
            REQ:       if (dc_st_ack) w_state_nxt = dc_st_uncached ? MMIO_WAIT : IDLE;
            MMIO_WAIT: if (dc_st_done) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // Grant is gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        load_req_grant = 1'b0;
        w_issue        = 1'b0;
        dc_st_req      = 1'b0;
        sb_pop         = 1'b0;
        mmio_busy      = 1'b0;
        fence_done     = 1'b0;
        case (r_state)
            IDLE: begin
                load_req_grant = rst_n && load_req_valid && !(w_store_eligible && w_urgent);
                w_issue        = w_store_eligible && !load_req_grant;
                fence_done     = r_fence_pending && (r_cnt == '0);
            end
            REQ: begin
                dc_st_req = 1'b1;
                sb_pop    = dc_st_ack;
            end
            MMIO_WAIT: mmio_busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt           <= '0;
            r_starve        <= '0;
            r_fence_pending <= 1'b0;
        end else begin
            r_cnt <= w_cnt_sum[CNT_W-1:0];
            if (fence_done)     r_fence_pending <= 1'b0;
            else if (fence_req) r_fence_pending <= 1'b1;
            if (r_state == IDLE) begin
                if (!w_store_eligible || w_issue)
                    r_starve <= '0;
                else if (load_req_grant && (r_starve != STALL_MAX))
                    r_starve <= r_starve + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_st_addr     <= '0;
            dc_st_data     <= '0;
            dc_st_mask     <= '0;
            dc_st_uncached <= 1'b0;
        end else if (w_issue) begin
            dc_st_addr     <= sb_head_addr;
            dc_st_data     <= sb_head_data;
            dc_st_mask     <= sb_head_mask;
            dc_st_uncached <= sb_head_non_idem;
        end
    end

    // Over-commit or underflow wraps into a value above SB_DEPTH.
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        w_cnt_sum <= (CNT_W+1)'(SB_DEPTH));

endmodule

// File: tb/tb_sb_drain_ctrl.sv
// tb/tb_sb_drain_ctrl.sv - directed self-checking bench for sb_drain_ctrl
module tb_sb_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  commit_store_cnt;
    logic        sb_head_valid;
    logic [31:0] sb_head_addr;
    logic [31:0] sb_head_data;
    logic [3:0]  sb_head_mask;
    logic        sb_head_non_idem;
    logic        sb_pop;
    logic        load_req_valid;
    logic        load_req_grant;
    logic        dc_st_req;
    logic [31:0] dc_st_addr;
    logic [31:0] dc_st_data;
    logic [3:0]  dc_st_mask;
    logic        dc_st_uncached;
    logic        dc_st_ack;
    logic        dc_st_done;
    logic        fence_req;
    logic        fence_done;
    logic [3:0]  committed_cnt;
    logic        mmio_busy;

    int checks = 0;
    int errors = 0;

    sb_drain_ctrl dut (
        .clk(clk), .rst_n(rst_n), .commit_store_cnt(commit_store_cnt),
        .sb_head_valid(sb_head_valid), .sb_head_addr(sb_head_addr),
        .sb_head_data(sb_head_data), .sb_head_mask(sb_head_mask),
        .sb_head_non_idem(sb_head_non_idem), .sb_pop(sb_pop),
        .load_req_valid(load_req_valid), .load_req_grant(load_req_grant),
        .dc_st_req(dc_st_req), .dc_st_addr(dc_st_addr), .dc_st_data(dc_st_data),
        .dc_st_mask(dc_st_mask), .dc_st_uncached(dc_st_uncached),
        .dc_st_ack(dc_st_ack), .dc_st_done(dc_st_done), .fence_req(fence_req),
        .fence_done(fence_done), .committed_cnt(committed_cnt), .mmio_busy(mmio_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; commit_store_cnt = 2'd2; sb_head_valid = 1'b0;
        sb_head_addr = '0; sb_head_data = '0; sb_head_mask = '0; sb_head_non_idem = 1'b0;
        load_req_valid = 1'b0; dc_st_ack = 1'b0; dc_st_done = 1'b0; fence_req = 1'b0;
        repeat (3) step();
        settle();
        checks++; if (committed_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", committed_cnt); end
        checks++; if ({dc_st_req, sb_pop, load_req_grant, fence_done, mmio_busy} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {dc_st_req, sb_pop, load_req_grant, fence_done, mmio_busy}); end
        checks++; if ({dc_st_addr, dc_st_data, dc_st_mask, dc_st_uncached} !== 69'd0) begin errors++; $display("FAIL reset_payload: got %h expected 0", {dc_st_addr, dc_st_data, dc_st_mask, dc_st_uncached}); end
        step();
        rst_n = 1'b1;
        step();
        commit_store_cnt = 2'd0;
        settle();
        checks++; if (committed_cnt !== 4'd2) begin errors++; $display("FAIL post_reset_cnt: got %0d expected 2", committed_cnt); end
        step();
        sb_head_valid = 1'b1; sb_head_addr = 32'h1000; sb_head_data = 32'hCAFE_0001; sb_head_mask = 4'hF;
        settle();
        checks++; if (load_req_grant !== 1'b0 || dc_st_req !== 1'b0) begin errors++; $display("FAIL idle_before_issue: got grant=%b req=%b expected 0 0", load_req_grant, dc_st_req); end
        step();
        settle();
        checks++; if (dc_st_req !== 1'b1 || dc_st_addr !== 32'h1000 || dc_st_data !== 32'hCAFE_0001 || dc_st_mask !== 4'hF) begin errors++; $display("FAIL first_req: got req=%b addr=%h data=%h mask=%h expected 1 1000 cafe0001 f", dc_st_req, dc_st_addr, dc_st_data, dc_st_mask); end
        checks++; if (sb_pop !== 1'b0) begin errors++; $display("FAIL pop_before_ack: got %b expected 0", sb_pop); end
        dc_st_ack = 1'b1;
        settle();
        checks++; if (sb_pop !== 1'b1) begin errors++; $display("FAIL pop_on_ack: got %b expected 1", sb_pop); end
        step();
        dc_st_ack = 1'b0; sb_head_valid = 1'b0;
        settle();
        checks++; if (committed_cnt !== 4'd1 || dc_st_req !== 1'b0 || sb_pop !== 1'b0) begin errors++; $display("FAIL after_ack: got cnt=%0d req=%b pop=%b expected 1 0 0", committed_cnt, dc_st_req, sb_pop); end
    endtask

    task automatic test_starvation();
        step();
        load_req_valid = 1'b1; sb_head_valid = 1'b1; sb_head_addr = 32'h1004;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (load_req_grant !== 1'b1 || dc_st_req !== 1'b0) begin errors++; $display("FAIL starve_grant_%0d: got grant=%b req=%b expected 1 0", i, load_req_grant, dc_st_req); end
            step();
        end
        settle();
        checks++; if (load_req_grant !== 1'b0) begin errors++; $display("FAIL starve_forced: got grant=%b expected 0", load_req_grant); end
        step();
        dc_st_ack = 1'b1;
        settle();
        checks++; if (dc_st_req !== 1'b1 || load_req_grant !== 1'b0 || sb_pop !== 1'b1 || dc_st_addr !== 32'h1004) begin errors++; $display("FAIL starve_req: got req=%b grant=%b pop=%b addr=%h expected 1 0 1 1004", dc_st_req, load_req_grant, sb_pop, dc_st_addr); end
        step();
        dc_st_ack = 1'b0;
        settle();
        checks++; if (committed_cnt !== 4'd0 || load_req_grant !== 1'b1) begin errors++; $display("FAIL starve_done: got cnt=%0d grant=%b expected 0 1", committed_cnt, load_req_grant); end
    endtask

    task automatic test_high_water();
        int pops;
        commit_store_cnt = 2'd2;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (load_req_grant !== 1'b1) begin errors++; $display("FAIL hw_grant_%0d: got %b expected 1", i, load_req_grant); end
            step();
        end
        commit_store_cnt = 2'd0;
        settle();
        checks++; if (committed_cnt !== 4'd6 || load_req_grant !== 1'b0) begin errors++; $display("FAIL hw_win: got cnt=%0d grant=%b expected 6 0", committed_cnt, load_req_grant); end
        step();
        settle();
        checks++; if (dc_st_req !== 1'b1) begin errors++; $display("FAIL hw_req: got %b expected 1", dc_st_req); end
        load_req_valid = 1'b0;
        pops = 0;
        for (int c = 0; c < 40 && committed_cnt != 4'd0; c++) begin
            step();
            dc_st_ack = dc_st_req;
            settle();
            if (sb_pop === 1'b1) pops++;
        end
        step();
        dc_st_ack = 1'b0;
        settle();
        checks++; if (pops !== 6 || committed_cnt !== 4'd0) begin errors++; $display("FAIL hw_drain: got pops=%0d cnt=%0d expected 6 0", pops, committed_cnt); end
    endtask

    task automatic test_mmio();
        commit_store_cnt = 2'd1; sb_head_valid = 1'b1; sb_head_non_idem = 1'b1; sb_head_addr = 32'h2000;
        step();
        commit_store_cnt = 2'd0;
        step();
        dc_st_ack = 1'b1;
        settle();
        checks++; if (dc_st_req !== 1'b1 || dc_st_uncached !== 1'b1 || sb_pop !== 1'b1) begin errors++; $display("FAIL mmio_req: got req=%b unc=%b pop=%b expected 1 1 1", dc_st_req, dc_st_uncached, sb_pop); end
        step();
        dc_st_ack = 1'b0; load_req_valid = 1'b1;
        commit_store_cnt = 2'd1; sb_head_non_idem = 1'b0; sb_head_addr = 32'h3000;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) dc_st_done = 1'b1;
            settle();
            checks++; if (mmio_busy !== 1'b1 || load_req_grant !== 1'b0 || dc_st_req !== 1'b0) begin errors++; $display("FAIL mmio_wait_%0d: got busy=%b grant=%b req=%b expected 1 0 0", k, mmio_busy, load_req_grant, dc_st_req); end
            step();
            commit_store_cnt = 2'd0;
        end
        dc_st_done = 1'b0; load_req_valid = 1'b0;
        settle();
        checks++; if (mmio_busy !== 1'b0 || committed_cnt !== 4'd1) begin errors++; $display("FAIL mmio_exit: got busy=%b cnt=%0d expected 0 1", mmio_busy, committed_cnt); end
        step();
        dc_st_ack = 1'b1;
        settle();
        checks++; if (dc_st_req !== 1'b1 || dc_st_addr !== 32'h3000 || dc_st_uncached !== 1'b0) begin errors++; $display("FAIL mmio_next: got req=%b addr=%h unc=%b expected 1 3000 0", dc_st_req, dc_st_addr, dc_st_uncached); end
        step();
        dc_st_ack = 1'b0;
        settle();
        checks++; if (mmio_busy !== 1'b0 || committed_cnt !== 4'd0) begin errors++; $display("FAIL mmio_cached_done: got busy=%b cnt=%0d expected 0 0", mmio_busy, committed_cnt); end
    endtask

    task automatic test_fence();
        int pops;
        int fdone;
        int fidx;
        sb_head_valid = 1'b0; commit_store_cnt = 2'd2;
        step();
        commit_store_cnt = 2'd1;
        step();
        commit_store_cnt = 2'd0;
        step();
        settle();
        checks++; if (committed_cnt !== 4'd3 || dc_st_req !== 1'b0) begin errors++; $display("FAIL fence_retain: got cnt=%0d req=%b expected 3 0", committed_cnt, dc_st_req); end
        step();
        load_req_valid = 1'b1; sb_head_valid = 1'b1; fence_req = 1'b1;
        settle();
        checks++; if (load_req_grant !== 1'b1 || fence_done !== 1'b0) begin errors++; $display("FAIL fence_pre: got grant=%b done=%b expected 1 0", load_req_grant, fence_done); end
        step();
        fence_req = 1'b0;
        pops = 0; fdone = 0; fidx = -1;
        for (int c = 0; c < 12; c++) begin
            dc_st_ack = dc_st_req;
            settle();
            if (sb_pop === 1'b1) pops++;
            if (fence_done === 1'b1) begin fdone++; fidx = c; end
            if (committed_cnt != 4'd0) begin
                checks++; if (load_req_grant !== 1'b0) begin errors++; $display("FAIL fence_load_denied_%0d: got %b expected 0", c, load_req_grant); end
            end
            step();
        end
        dc_st_ack = 1'b0;
        checks++; if (pops !== 3 || fdone !== 1 || fidx !== 6) begin errors++; $display("FAIL fence_drain: got pops=%0d done=%0d at=%0d expected 3 1 6", pops, fdone, fidx); end
        load_req_valid = 1'b0; fence_req = 1'b1;
        settle();
        checks++; if (fence_done !== 1'b0) begin errors++; $display("FAIL fence_empty_early: got %b expected 0", fence_done); end
        step();
        fence_req = 1'b0;
        settle();
        checks++; if (fence_done !== 1'b1) begin errors++; $display("FAIL fence_empty_done: got %b expected 1", fence_done); end
        step();
        settle();
        checks++; if (fence_done !== 1'b0) begin errors++; $display("FAIL fence_empty_pulse: got %b expected 0", fence_done); end
    endtask

    task automatic test_back_to_back();
        step();
        commit_store_cnt = 2'd1; sb_head_valid = 1'b1; sb_head_addr = 32'h4000;
        step();
        commit_store_cnt = 2'd0;
        step();
        commit_store_cnt = 2'd1; dc_st_ack = 1'b1;
        settle();
        checks++; if (sb_pop !== 1'b1) begin errors++; $display("FAIL b2b_pop: got %b expected 1", sb_pop); end
        step();
        commit_store_cnt = 2'd0; dc_st_ack = 1'b0;
        settle();
        checks++; if (committed_cnt !== 4'd1) begin errors++; $display("FAIL b2b_cnt: got %0d expected 1", committed_cnt); end
        step();
        settle();
        checks++; if (dc_st_req !== 1'b1) begin errors++; $display("FAIL b2b_req: got %b expected 1", dc_st_req); end
        dc_st_ack = 1'b1; load_req_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if ({dc_st_req, sb_pop, load_req_grant, fence_done, mmio_busy} !== 5'b0 || committed_cnt !== 4'd0 || dc_st_addr !== 32'd0) begin errors++; $display("FAIL async_reset: got ctrl=%b cnt=%0d addr=%h expected 00000 0 0", {dc_st_req, sb_pop, load_req_grant, fence_done, mmio_busy}, committed_cnt, dc_st_addr); end
        step();
        dc_st_ack = 1'b0; load_req_valid = 1'b0; sb_head_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_starvation();
        test_high_water();
        test_mmio();
        test_fence();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
